// File: rtl/gram_param_if.sv
// Bus bundle for gram_param: write/clear requests and address/data in, read data and busy flag out.
// The master side drives requests; the memory is the slave.
interface gram_param_if #(
  parameter int LARGURA      = 16,
  parameter int PROFUNDIDADE = 8
);
  localparam int END_W = $clog2(PROFUNDIDADE);

  logic             habilita_in;
  logic             limpa_in;
  logic [END_W-1:0] endereco_in;
  logic [LARGURA-1:0] dado_in;
  logic [LARGURA-1:0] dado_out;
  logic             ocupado_out;

  modport master (
    output habilita_in, limpa_in, endereco_in, dado_in,
    input  dado_out, ocupado_out
  );

  modport slave (
    input  habilita_in, limpa_in, endereco_in, dado_in,
    output dado_out, ocupado_out
  );
endinterface

// File: rtl/gram_param.sv
// Parametrised single-port data memory with a hardware clear sweep after reset or on request,
// a busy flag, and either a combinational or a registered (write-first) read port.
module gram_param #(
  parameter int LARGURA      = 16,
  parameter int PROFUNDIDADE = 8,
  parameter int LEITURA_REG  = 0
) (
  input logic         relogio_in,
  input logic         reinicia_in,
  gram_param_if.slave bus
);
  localparam int END_W = $clog2(PROFUNDIDADE);
  localparam logic [END_W-1:0] LAST      = END_W'(PROFUNDIDADE - 1);
  localparam logic [END_W:0]   DEPTH_LIM = (END_W + 1)'(PROFUNDIDADE);

  typedef enum logic {LIMPANDO = 1'b0, PRONTO = 1'b1} state_t;

  state_t             state_reg, state_next;
  logic [END_W-1:0]   cont_reg, cont_next;
  logic [LARGURA-1:0] mem [PROFUNDIDADE];

  logic               addr_ok;
  logic               busy;
  logic               mem_we;
  logic [END_W-1:0]   mem_waddr;
  logic [LARGURA-1:0] mem_wdata;

  // Only non-power-of-2 depths can present an address past the last word.
  assign addr_ok = ({1'b0, bus.endereco_in} < DEPTH_LIM);

  always_ff @(posedge relogio_in) begin
    if (reinicia_in) begin
      state_reg <= LIMPANDO;
      cont_reg  <= '0;
    end else begin
      state_reg <= state_next;
      cont_reg  <= cont_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    cont_next  = cont_reg;
    case (state_reg)
      LIMPANDO: begin
        if (cont_reg == LAST) begin
          state_next = PRONTO;
          cont_next  = '0;
        end else begin
          cont_next = cont_reg + 1'b1;
        end
      end
      PRONTO: begin
        if (bus.limpa_in) begin
          state_next = LIMPANDO;
          cont_next  = '0;
        end
      end
      default: begin
        state_next = LIMPANDO;
        cont_next  = '0;
      end
    endcase
  end

  // A clear request in PRONTO wins over a simultaneous user write.
  always_comb begin
    busy      = reinicia_in || (state_reg == LIMPANDO);
    mem_we    = 1'b0;
    mem_waddr = bus.endereco_in;
    mem_wdata = bus.dado_in;
    if (!reinicia_in) begin
      if (state_reg == LIMPANDO) begin
        mem_we    = 1'b1;
        mem_waddr = cont_reg;
        mem_wdata = '0;
      end else if (!bus.limpa_in && bus.habilita_in && addr_ok) begin
        mem_we = 1'b1;
      end
    end
  end

  always_ff @(posedge relogio_in) begin
    if (mem_we) begin
      mem[mem_waddr] <= mem_wdata;
    end
  end

  assign bus.ocupado_out = busy;

  generate
    if (LEITURA_REG != 0) begin : g_read_reg
      logic [LARGURA-1:0] rd_reg;

      always_ff @(posedge relogio_in) begin
        if (reinicia_in || (state_reg == LIMPANDO) || bus.limpa_in || !addr_ok) begin
          rd_reg <= '0;
        end else if (bus.habilita_in) begin
          rd_reg <= bus.dado_in;
        end else begin
          rd_reg <= mem[bus.endereco_in];
        end
      end

      assign bus.dado_out = rd_reg;
    end else begin : g_read_comb
      assign bus.dado_out = (busy || !addr_ok) ? '0 : mem[bus.endereco_in];
    end
  endgenerate
endmodule

// File: doc/gram_param.md
Name: gram_param

Overview:
Parametrised successor to the fixed 8x16 RAM. Width, depth and read mode are configurable. It adds a synchronous reset that starts a hardware clear sweep of every word, a software clear request, a busy flag, and an optional registered read port. It is the general-purpose data memory for the program-counter/memory datapath.

Parameters:
LARGURA, 16, word width in bits (>=1)
PROFUNDIDADE, 8, number of words (>=2, need not be a power of 2)
LEITURA_REG, 0, 0 = combinational read (RAM8-compatible); 1 = registered read, 1-cycle latency
END_W (localparam), $clog2(PROFUNDIDADE), address width

Ports:
relogio_in  input  1  clock, all state updates on rising edge
reinicia_in  input  1  synchronous active-high reset
habilita_in  input  1  write enable
limpa_in  input  1  clear-sweep request (single-cycle pulse or level)
endereco_in  input  END_W  read/write address
dado_in  input  LARGURA  write data
dado_out  output  LARGURA  read data
ocupado_out  output  1  high while a clear sweep is running or reset is held

Behaviour:
- FSM states: LIMPANDO, PRONTO. Internal counter cont[END_W-1:0].
- Reset (reinicia_in=1 at edge):
  - state goes to LIMPANDO; cont=0; ocupado_out=1.
  - dado_out register (LEITURA_REG=1) is cleared to 0.
  - no memory write occurs while reset is held.
  - reset overrides all other inputs, including mid-sweep; the sweep restarts from 0.
- LIMPANDO, reset low:
  - each edge writes 0 to mem[cont], then increments cont.
  - the edge that writes word PROFUNDIDADE-1 moves the state to PRONTO. ocupado_out falls exactly PROFUNDIDADE edges after the first edge with reinicia_in=0.
  - habilita_in and limpa_in are ignored.
  - dado_out is forced to 0 in both read modes.
- PRONTO:
  - limpa_in=1 at an edge: state goes to LIMPANDO, cont=0, and that edge performs no user write even if habilita_in=1 (clear has priority).
  - habilita_in=1 with endereco_in<PROFUNDIDADE: mem[endereco_in] <= dado_in at the edge.
  - habilita_in=0: memory is unchanged.
- Out-of-range address (endereco_in>=PROFUNDIDADE, non-power-of-2 depth only):
  - writes are ignored.
  - reads return 0.
- Read, LEITURA_REG=0: dado_out = mem[endereco_in] combinationally. A write is visible immediately after the writing edge.
- Read, LEITURA_REG=1:
  - dado_out is registered each edge from the address presented at that edge.
  - same-address read during write returns dado_in (write-first).
  - latency is 1 edge.
  - the first edge of a sweep (and a reset edge) loads 0.
- Memory contents are undefined only before the first reset; after any completed sweep every word = 0.
- No arithmetic beyond the cont increment. cont never exceeds PROFUNDIDADE-1: the state leaves LIMPANDO on that value, so there is no wrap.

Test Plan:
- Reset sweep (defaults): hold reinicia_in=1 for 3 edges, then release -> ocupado_out=1 for exactly 8 edges after release, then 0; reading addresses 0..7 all give 0x0000.
- Write/read (LEITURA_REG=0): write 0xAAAA@0, 0x5555@1, ..., 0x55AA@7 with habilita_in=1, then habilita_in=0 and sweep addresses -> each word read back the same cycle; write with habilita_in=0, dado_in=0xFFFF@0 -> word 0 stays 0xAAAA.
- Registered read (LEITURA_REG=1): write 0x1234@3, then read @3 -> dado_out=0x1234 one edge later. Same-edge write 0xBEEF@5 with address 5 -> dado_out=0xBEEF after that edge.
- Clear request: fill all words with 0xFFFF; pulse limpa_in with habilita_in=1, dado_in=0x0F0F@2 -> no write to word 2; ocupado_out high 8 edges; all words read 0; dado_out=0 throughout.
- Reset mid-sweep: assert reinicia_in at the 4th sweep edge for 1 edge -> sweep restarts; ocupado_out stays high 8 edges after release; writes during busy are ignored.
- Non-power-of-2 (PROFUNDIDADE=5, LARGURA=8): write 0x7E@6 -> ignored; read @6 gives 0x00; sweep length is 5 edges.
